fp_to_int: RTL and testbench

Sequential IEEE-754 single-precision to signed 32-bit integer converter. It is the unpacking counterpart of the floating-point adder's normalise/round/pack path: it takes a packed float32 and decodes it into a two's-complement integer. Conversion truncates toward zero. The mantissa is aligned by a one-bit-per-cycle shifter under a small FSM with a start/busy/done handshake. It sits downstream of the adder result, or on any path that needs an integer view of a float.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_unpack.sv | 27 ++
 rtl/fp_to_int.sv | 140 ++++++++++++++
 tb/tb_fp_to_int.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float32 constants and state/outcome types.
// The adder path reuses this package for its bias and exponent limits.
package fp_pkg;
  localparam int          FP_BIAS     = 127;
  localparam int          FP_EXP_MAX  = 255;
  localparam logic [31:0] INT32_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN   = 32'h8000_0000;
  localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [1:0] {IDLE, CLASS, SHIFT, FIN} state_t;

  // What FIN should emit, decided once in CLASS.
  typedef enum logic [1:0] {OUT_NUM, OUT_ZERO, OUT_INV, OUT_MIN} outcome_t;
endpackage

// File: rtl/fp_unpack.sv
// Combinational float32 field split and classification.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       x,
  output logic              sign,
  output logic [7:0]        exponent,
  output logic [23:0]       mantissa,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero_or_sub,
  output logic signed [8:0] k
);
  logic frac_nz;
  logic exp_max;

  assign sign           = x[31];
  assign exponent       = x[30:23];
  assign frac_nz        = |x[22:0];
  assign exp_max        = (exponent == 8'(FP_EXP_MAX));
  assign is_zero_or_sub = (exponent == 8'd0);
  // Hidden bit is clear for zeros and denormals.
  assign mantissa       = {~is_zero_or_sub, x[22:0]};
  assign is_nan         = exp_max & frac_nz;
  assign is_inf         = exp_max & ~frac_nz;
  assign k              = $signed({1'b0, exponent}) - $signed(9'(FP_BIAS));
endmodule

// File: rtl/fp_to_int.sv
// Sequential float32 -> int32 converter, truncating toward zero.
// Mantissa alignment uses a one-bit-per-cycle shifter under a start/busy/done FSM.
module fp_to_int
  import fp_pkg::*;
#(
  parameter bit SAT_ON_INVALID = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        inexact
);
  state_t      state;
  outcome_t    outcome;
  logic [31:0] x_q;
  logic [31:0] shreg;
  logic [4:0]  cnt;
  logic        left_q;
  logic        sticky;

  logic              sign;
  logic [7:0]        exponent;
  logic [23:0]       mantissa;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero_or_sub;
  logic signed [8:0] k;

  fp_unpack u_unpack (
    .x              (x_q),
    .sign           (sign),
    .exponent       (exponent),
    .mantissa       (mantissa),
    .is_nan         (is_nan),
    .is_inf         (is_inf),
    .is_zero_or_sub (is_zero_or_sub),
    .k              (k)
  );

  // Alignment against the binary point at bit 23; only used when 0 <= k <= 30.
  logic        shift_left;
  logic [4:0]  shift_n;
  logic [31:0] inv_val;

  assign shift_left = (k > 9'sd23);
  assign shift_n    = shift_left ? 5'(k - 9'sd23) : 5'(9'sd23 - k);
  assign inv_val    = !SAT_ON_INVALID       ? 32'd0     :
                      (is_nan || !sign)     ? INT32_MAX : INT32_MIN;

  // NOTE: async reset clears every register, including the datapath, so an
  // aborted conversion leaves no stale shifter state; all state uses <=.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      outcome <= OUT_NUM;
      x_q     <= '0;
      shreg   <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      sticky  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_q   <= x;
            busy  <= 1'b1;
            state <= CLASS;
          end
        end
        CLASS: begin
          state <= FIN;
          if (is_nan || is_inf) begin
            outcome <= OUT_INV;
          end else if (is_zero_or_sub || k < 9'sd0) begin
            outcome <= OUT_ZERO;
            sticky  <= (exponent != 8'd0) || (|mantissa[22:0]);
          end else if (k >= 9'sd31) begin
            outcome <= (x_q == FP_NEG_2P31) ? OUT_MIN : OUT_INV;
          end else begin
            outcome <= OUT_NUM;
            shreg   <= {8'd0, mantissa};
            cnt     <= shift_n;
            left_q  <= shift_left;
            sticky  <= 1'b0;
            if (shift_n != 5'd0) state <= SHIFT;
          end
        end
        SHIFT: begin
          if (left_q) begin
            shreg <= {shreg[30:0], 1'b0};
          end else begin
            shreg  <= {1'b0, shreg[31:1]};
            sticky <= sticky | shreg[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= FIN;
        end
        FIN: begin
          case (outcome)
            OUT_INV: begin
              result  <= inv_val;
              invalid <= 1'b1;
              inexact <= 1'b0;
            end
            OUT_MIN: begin
              result  <= INT32_MIN;
              invalid <= 1'b0;
              inexact <= 1'b0;
            end
            OUT_ZERO: begin
              result  <= '0;
              invalid <= 1'b0;
              inexact <= sticky;
            end
            default: begin
              result  <= sign ? -shreg : shreg;
              invalid <= 1'b0;
              inexact <= sticky;
            end
          endcase
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_int.sv
// Directed-vector bench for fp_to_int; a second instance runs with saturation off.
module tb_fp_to_int;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] x;

  logic        busy, done, invalid, inexact;
  logic [31:0] result;
  logic        busy0, done0, invalid0, inexact0;
  logic [31:0] result0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_to_int #(.SAT_ON_INVALID(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x),
    .busy(busy), .done(done), .result(result), .invalid(invalid), .inexact(inexact)
  );

  fp_to_int #(.SAT_ON_INVALID(1'b0)) dut_nosat (
    .clk(clk), .reset(reset), .start(start), .x(x),
    .busy(busy0), .done(done0), .result(result0), .invalid(invalid0), .inexact(inexact0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts one conversion and checks latency, busy length and all outputs.
  task automatic run(input string tag, input logic [31:0] xv, input logic [31:0] er,
                     input logic ei, input logic ee, input int eedge, input logic [31:0] er0);
    int edges;
    int busy_cycles;
    @(negedge clk);
    x     = xv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    edges       = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cycles++;
    end
    check({tag, " done_edge"}, 32'(edges), 32'(eedge));
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(eedge));
    check({tag, " result"}, result, er);
    check({tag, " invalid"}, 32'(invalid), 32'(ei));
    check({tag, " inexact"}, 32'(inexact), 32'(ee));
    check({tag, " nosat_result"}, result0, er0);
    check({tag, " nosat_invalid"}, 32'(invalid0), 32'(ei));
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", {30'd0, invalid, inexact}, 32'd0);
    reset = 1'b0;

    //   tag         x             result        inv   inex  edge  nosat result
    run("one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25, 32'h0000_0001);
    run("neg2p5",   32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 24, 32'hFFFF_FFFE);
    run("half",     32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1,  2, 32'h0000_0000);
    run("negzero",  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0,  2, 32'h0000_0000);
    run("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1,  2, 32'h0000_0000);
    run("n0",       32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0,  2, 32'h0080_0001);
    run("m123p5",   32'hC2F7_0000, 32'hFFFF_FF85, 1'b0, 1'b1, 19, 32'hFFFF_FF85);
    run("maxleft",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0,  9, 32'h7FFF_FF80);
    run("neg2p31",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0,  2, 32'h8000_0000);
    run("pos2p31",  32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  2, 32'h0000_0000);
    run("neginf",   32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0,  2, 32'h0000_0000);
    run("qnan",     32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  2, 32'h0000_0000);
    run("negnan",   32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  2, 32'h0000_0000);

    // Leave a nonzero result behind, then abort a 1.0 conversion mid-shift.
    run("pre_abort", 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 24, 32'hFFFF_FFFE);
    @(negedge clk);
    x     = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", {30'd0, invalid, inexact}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    run("three", 32'h4040_0000, 32'h0000_0003, 1'b0, 1'b0, 24, 32'h0000_0003);

    // A start pulse during a busy conversion must be dropped, not queued.
    @(negedge clk);
    x     = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    x     = 32'h4120_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) dones++;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("busy_start dones", 32'(dones), 32'd1);
    check("busy_start result", result, 32'h0000_0001);
    check("busy_start idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
